// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: read-side drainer for an async FIFO.
// Pops words from the FIFO's combinational read port into a two-entry
// head/skid buffer and presents them as an AXI4-Stream master. Words are
// grouped into fixed-length frames (tlast on the final word), and completed
// frames are counted.
module fifo_axis_reader #(
  parameter int DATA_WIDTH  = 512,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int FRAME_WORDS = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic                  busy
);

  // A one-word frame still needs a 1-bit index so the compare stays legal.
  localparam int               IDX_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic [CNT_WIDTH-1:0]  frame_count_q, frame_count_d;

  logic pop_s;
  logic hs_s;
  logic tvalid_s;
  logic new_last_s;

  // The head entry is the stream output whenever anything is buffered.
  assign tvalid_s   = (occ_q != 2'd0);
  // Pops are refused while held in reset, while empty, or with both entries full.
  assign pop_s      = ~rd_rst & enable & ~fifo_empty & (occ_q < 2'd2);
  assign hs_s       = tvalid_s & m_axis_tready;
  assign new_last_s = (word_idx_q == LAST_IDX);

  assign fifo_rd_en    = pop_s;
  assign m_axis_tdata  = head_data_q;
  assign m_axis_tkeep  = {KEEP_WIDTH{1'b1}};
  assign m_axis_tvalid = tvalid_s;
  assign m_axis_tlast  = head_last_q;
  assign frame_count   = frame_count_q;
  assign busy          = tvalid_s;

  // Head/skid buffer: place popped words and advance on output handshakes.
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    case ({pop_s, hs_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_data_d = fifo_data_out;
          head_last_d = new_last_s;
        end else begin
          skid_data_d = fifo_data_out;
          skid_last_d = new_last_s;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_data_d = skid_data_q;
        head_last_d = skid_last_q;
        occ_d       = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_data_d = fifo_data_out;
          head_last_d = new_last_s;
        end else begin
          // Full buffer blocks pops; shift anyway so nothing could be dropped.
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
          skid_data_d = fifo_data_out;
          skid_last_d = new_last_s;
        end
        occ_d = occ_q;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Frame position advances per popped word, so tlast is fixed at pop time.
  always_comb begin
    if (pop_s) begin
      if (new_last_s) begin
        word_idx_d = {IDX_W{1'b0}};
      end else begin
        word_idx_d = word_idx_q + IDX_W'(1);
      end
    end else begin
      word_idx_d = word_idx_q;
    end
  end

  // A frame completes when its tlast beat is accepted downstream.
  always_comb begin
    if (hs_s && head_last_q) begin
      frame_count_d = frame_count_q + CNT_WIDTH'(1);
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // State registers; reset discards buffered words and restarts framing.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ_q         <= 2'd0;
      head_data_q   <= {DATA_WIDTH{1'b0}};
      head_last_q   <= 1'b0;
      skid_data_q   <= {DATA_WIDTH{1'b0}};
      skid_last_q   <= 1'b0;
      word_idx_q    <= {IDX_W{1'b0}};
      frame_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      occ_q         <= occ_d;
      head_data_q   <= head_data_d;
      head_last_q   <= head_last_d;
      skid_data_q   <= skid_data_d;
      skid_last_q   <= skid_last_d;
      word_idx_q    <= word_idx_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Testbench for fifo_axis_reader: a behavioural FIFO feeds the DUT, the
// stimulus pushes each word's expected beat into a scoreboard, and a
// negedge monitor compares every stream beat and the pop/valid behaviour.
// A second instance (one-word frames, 2-bit counter) exercises counter wrap.
module tb_fifo_axis_reader;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic tready = 1'b0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  // Main DUT signals
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic [31:0]   frame_count;
  logic          busy;

  // Second DUT signals
  logic          en2 = 1'b0;
  logic          rd_en2;
  logic [DW-1:0] data2;
  logic          empty2;
  logic [DW-1:0] tdata2;
  logic [KW-1:0] tkeep2;
  logic          tvalid2;
  logic          tlast2;
  logic [1:0]    fc2;
  logic          busy2;

  fifo_axis_reader #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .CNT_WIDTH(32)) dut (
    .rd_clk(clk), .rd_rst(rst), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data), .fifo_empty(fifo_empty),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(tready), .m_axis_tlast(m_tlast),
    .frame_count(frame_count), .busy(busy)
  );

  fifo_axis_reader #(.DATA_WIDTH(DW), .FRAME_WORDS(1), .CNT_WIDTH(2)) dut2 (
    .rd_clk(clk), .rd_rst(rst), .enable(en2),
    .fifo_rd_en(rd_en2), .fifo_data_out(data2), .fifo_empty(empty2),
    .m_axis_tdata(tdata2), .m_axis_tkeep(tkeep2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(1'b1), .m_axis_tlast(tlast2),
    .frame_count(fc2), .busy(busy2)
  );

  // Behavioural FIFO for the main DUT: combinational read port.
  logic [DW-1:0] fifo_mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[9:0]];

  // FIFO read pointer follows the DUT's pop requests.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  // Counting FIFO for the second DUT: data is the word's sequence number.
  int pushed2 = 0;
  int popped2 = 0;
  assign empty2 = (popped2 == pushed2);
  assign data2  = DW'(popped2);

  // Second FIFO read pointer.
  always @(posedge clk or posedge rst) begin
    if (rst) popped2 <= pushed2;
    else if (rd_en2) popped2 <= popped2 + 1;
  end

  // Scoreboard (written by stimulus, consumed by the monitor)
  logic [DW-1:0] exp_data [1024];
  logic          exp_last [1024];
  int exp_wr = 0;
  int exp_rd = 0;
  int word_cnt = 0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
  endtask

  // Stimulus helpers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_mem[wr_ptr[9:0]] = v;
    exp_data[exp_wr[9:0]] = v;
    exp_last[exp_wr[9:0]] = ((word_cnt % FW) == (FW - 1));
    word_cnt++;
    wr_ptr++;
    exp_wr++;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_rd != exp_wr; i++) cycle();
    repeat (2) cycle();
  endtask

  // Monitor state
  int         occ_m = 0;
  int         stall_cnt = 0;
  logic [31:0] exp_fc = 32'd0;
  logic [1:0] exp_fc2 = 2'd0;
  int         exp2_rd = 0;
  bit         stalled = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic       prev_last = 1'b0;

  // Monitor: compares the DUT against the reference model once per cycle.
  always @(negedge clk) begin
    bit hs;
    bit exp_en;
    if (rst) begin
      chk(m_tvalid == 1'b0, "rst_tvalid", 64'(m_tvalid), 64'd0);
      chk(fifo_rd_en == 1'b0, "rst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
      chk(m_tlast == 1'b0, "rst_tlast", 64'(m_tlast), 64'd0);
      chk(m_tdata == '0, "rst_tdata", m_tdata, 64'd0);
      chk(frame_count == 32'd0, "rst_frame_count", 64'(frame_count), 64'd0);
      chk(tvalid2 == 1'b0 && fc2 == 2'd0, "rst_dut2", 64'({tvalid2, fc2}), 64'd0);
      exp_rd = exp_wr;
      exp_fc = 32'd0;
      exp_fc2 = 2'd0;
      exp2_rd = pushed2;
      occ_m = 0;
      stall_cnt = 0;
      stalled = 1'b0;
    end else begin
      hs = m_tvalid && tready;
      exp_en = enable && !fifo_empty && (occ_m < 2);
      chk(fifo_rd_en == exp_en, "rd_en", 64'(fifo_rd_en), 64'(exp_en));
      chk(m_tvalid == (occ_m != 0), "tvalid", 64'(m_tvalid), 64'(occ_m != 0));
      chk(busy == (occ_m != 0), "busy", 64'(busy), 64'(occ_m != 0));
      if (m_tvalid) chk(m_tkeep == {KW{1'b1}}, "tkeep", 64'(m_tkeep), 64'(KW'('1)));
      if (stalled) begin
        chk(m_tvalid == 1'b1, "stall_valid_held", 64'(m_tvalid), 64'd1);
        chk(m_tdata == prev_data, "stall_tdata_held", m_tdata, prev_data);
        chk(m_tlast == prev_last, "stall_tlast_held", 64'(m_tlast), 64'(prev_last));
      end
      chk(frame_count == exp_fc, "frame_count", 64'(frame_count), 64'(exp_fc));
      if (hs) begin
        chk(exp_rd != exp_wr, "beat_expected", 64'(exp_rd), 64'(exp_wr));
        if (exp_rd != exp_wr) begin
          chk(m_tdata == exp_data[exp_rd[9:0]], "tdata", m_tdata, exp_data[exp_rd[9:0]]);
          chk(m_tlast == exp_last[exp_rd[9:0]], "tlast", 64'(m_tlast), 64'(exp_last[exp_rd[9:0]]));
          if (exp_last[exp_rd[9:0]]) exp_fc = exp_fc + 32'd1;
          exp_rd++;
        end
        stall_cnt = 0;
      end else if (exp_rd != exp_wr) begin
        stall_cnt++;
      end else begin
        stall_cnt = 0;
      end
      chk(stall_cnt < 100, "progress_timeout", 64'(stall_cnt), 64'd100);
      occ_m = occ_m + (fifo_rd_en ? 1 : 0) - (hs ? 1 : 0);
      stalled = m_tvalid && !tready;
      prev_data = m_tdata;
      prev_last = m_tlast;

      // Second instance: every word is a frame; counter wraps modulo 4.
      chk(fc2 == exp_fc2, "dut2_frame_count", 64'(fc2), 64'(exp_fc2));
      if (tvalid2) begin
        chk(tlast2 == 1'b1, "dut2_tlast", 64'(tlast2), 64'd1);
        chk(tdata2 == DW'(exp2_rd), "dut2_tdata", tdata2, DW'(exp2_rd));
        exp2_rd++;
        exp_fc2 = exp_fc2 + 2'd1;
      end

      if (done) begin
        chk(exp_rd == exp_wr, "scoreboard_drained", 64'(exp_rd), 64'(exp_wr));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  // Absolute time bound in case the run stalls completely.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // Stimulus
  initial begin
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Eight words, free-flowing output: two frames, back-to-back beats.
    enable = 1'b1;
    tready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    drain();

    // Frame counter wrap on the one-word-frame instance: five frames.
    en2 = 1'b1;
    pushed2 = pushed2 + 5;
    repeat (10) cycle();

    // Backpressure with three words: two pops, then held until ready.
    tready = 1'b0;
    for (int i = 1; i <= 3; i++) push(DW'(i));
    repeat (6) cycle();
    tready = 1'b1;
    drain();

    // Alternating ready over eight words.
    for (int i = 1; i <= 8; i++) push(DW'(8'h10 + i));
    for (int i = 0; i < 24; i++) begin
      tready = (i % 2 == 0);
      cycle();
    end
    tready = 1'b1;
    drain();

    // Realign to a frame boundary, then pause enable after two pops.
    while ((word_cnt % FW) != 0) push(DW'(8'hEE));
    drain();
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) push(DW'(8'h20 + i));
    enable = 1'b1;
    cycle();
    cycle();
    enable = 1'b0;
    repeat (10) cycle();
    enable = 1'b1;
    drain();

    // Asynchronous reset mid-cycle with the buffer full.
    tready = 1'b0;
    for (int i = 1; i <= 4; i++) push(DW'(8'h30 + i));
    repeat (4) cycle();
    #2;
    rst = 1'b1;
    word_cnt = 0;
    cycle();
    cycle();
    rst = 1'b0;
    tready = 1'b1;
    cycle();
    for (int i = 1; i <= 4; i++) push(DW'(8'h40 + i));
    drain();

    // Randomized traffic, ready and enable.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) push({$urandom, $urandom});
      tready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 9) != 0);
      cycle();
    end
    tready = 1'b1;
    enable = 1'b1;
    drain();

    done = 1'b1;
  end

endmodule
